psram_qpi_responder: RTL and testbench



---
 rtl/psram_qpi_responder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: SPI/QPI PSRAM device emulator backed by an internal byte RAM.
// Oversamples sclk/ce/sio on clk (>= 4x sclk). It decodes the SPI init commands and
// the QPI 0x38 write / 0xEB fast-read commands.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   sclk, ce, sio_in    bus from the controller (ce active low, sio_in = {sio3,sio2,miso,mosi})
//   sio_out, sio_oe     bus data driven back; sio_oe=1 drives all four lines
//   qpi_mode, cmd_err   current bus mode; sticky unknown-opcode flag
//   dbg_*               backdoor RAM access, dbg_rdata has 1-cycle latency
module psram_qpi_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  ce,
  input  logic [3:0]            sio_in,
  output logic [3:0]            sio_out,
  output logic                  sio_oe,
  output logic                  qpi_mode,
  output logic                  cmd_err,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [7:0]            dbg_wdata,
  output logic [7:0]            dbg_rdata
);
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

  localparam logic [7:0] OP_RST_EN = 8'h66;
  localparam logic [7:0] OP_RST    = 8'h99;
  localparam logic [7:0] OP_QPI_EN = 8'h35;
  localparam logic [7:0] OP_QPI_EX = 8'hF5;
  localparam logic [7:0] OP_WRITE  = 8'h38;
  localparam logic [7:0] OP_READ   = 8'hEB;

  typedef enum logic [2:0] {
    S_CMD, S_IGNORE, S_ADDR, S_WDATA, S_WAIT, S_RDATA
  } state_t;

  state_t state, state_d;

  // Input synchronisers plus one extra sclk stage for edge detection
  logic       sclk_m, sclk_s, sclk_d;
  logic       ce_m, ce_s;
  logic [3:0] sio_m, sio_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      ce_m   <= 1'b1;
      ce_s   <= 1'b1;
      sio_m  <= 4'h0;
      sio_s  <= 4'h0;
    end else begin
      sclk_m <= sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      ce_m   <= ce;
      ce_s   <= ce_m;
      sio_m  <= sio_in;
      sio_s  <= sio_m;
    end
  end

  logic rise_c, fall_c;
  assign rise_c = sclk_s & ~sclk_d;
  assign fall_c = ~sclk_s & sclk_d;

  // Datapath registers
  logic [2:0]            bit_cnt;
  logic [6:0]            cmd_sr;
  logic [2:0]            nib_cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  is_read;
  logic [3:0]            w_hi;
  logic                  w_phase;
  logic [WAIT_W-1:0]     wait_cnt;
  logic                  rd_lo;
  logic [7:0]            rd_byte;
  logic                  armed;

  logic [7:0]            cmd_byte_c;
  logic                  cmd_last_c, cmd_done_c;
  logic [ADDR_WIDTH-1:0] addr_nx_c;
  logic                  addr_last_c, wait_last_c, bus_we_c;

  // Opcode assembled from the bits/nibbles received so far plus the current sample
  always_comb begin
    if (qpi_mode) cmd_byte_c = {cmd_sr[3:0], sio_s};
    else          cmd_byte_c = {cmd_sr[6:0], sio_s[0]};
  end

  assign cmd_last_c  = qpi_mode ? (bit_cnt == 3'd1) : (bit_cnt == 3'd7);
  assign cmd_done_c  = (state == S_CMD) && rise_c && cmd_last_c && !ce_s;
  assign addr_nx_c   = ADDR_WIDTH'({addr_sr, sio_s});
  assign addr_last_c = (nib_cnt == 3'd5);
  assign wait_last_c = (wait_cnt == WAIT_LAST);
  assign bus_we_c    = (state == S_WDATA) && rise_c && w_phase && !ce_s && !rst;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_CMD;
    else     state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    if (ce_s) begin
      state_d = S_CMD;
    end else begin
      case (state)
        S_CMD: begin
          if (cmd_done_c) begin
            if (qpi_mode && (cmd_byte_c == OP_WRITE || cmd_byte_c == OP_READ)) state_d = S_ADDR;
            else                                                               state_d = S_IGNORE;
          end
        end
        S_ADDR:  if (rise_c && addr_last_c) state_d = is_read ? S_WAIT : S_WDATA;
        S_WAIT:  if (fall_c && wait_last_c) state_d = S_RDATA;
        default: ;
      endcase
    end
  end

  // Output logic: next values of the registered outputs and the reset-enable flag
  logic [3:0] sio_out_d;
  logic       sio_oe_d, qpi_d, err_d, armed_d;

  always_comb begin
    sio_out_d = sio_out;
    sio_oe_d  = sio_oe;
    qpi_d     = qpi_mode;
    err_d     = cmd_err;
    armed_d   = armed;
    if (ce_s) begin
      sio_oe_d = 1'b0;
    end else begin
      case (state)
        S_CMD: begin
          if (cmd_done_c) begin
            armed_d = 1'b0;
            case (cmd_byte_c)
              OP_RST_EN: armed_d = 1'b1;
              OP_RST:    if (armed) qpi_d = 1'b0;
              OP_QPI_EN: if (!qpi_mode) qpi_d = 1'b1; else err_d = 1'b1;
              OP_QPI_EX: if (qpi_mode) qpi_d = 1'b0; else err_d = 1'b1;
              OP_WRITE,
              OP_READ:   if (!qpi_mode) err_d = 1'b1;
              default:   err_d = 1'b1;
            endcase
          end
        end
        S_WAIT: begin
          if (fall_c && wait_last_c) begin
            sio_oe_d  = 1'b1;
            sio_out_d = rd_byte[7:4];
          end
        end
        // rd_byte already holds the next byte by the time the high nibble is due
        S_RDATA: if (fall_c) sio_out_d = rd_lo ? rd_byte[3:0] : rd_byte[7:4];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sio_out  <= 4'h0;
      sio_oe   <= 1'b0;
      qpi_mode <= 1'b0;
      cmd_err  <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sio_out  <= sio_out_d;
      sio_oe   <= sio_oe_d;
      qpi_mode <= qpi_d;
      cmd_err  <= err_d;
      armed    <= armed_d;
    end
  end

  // Counters, shift registers and RAM pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= 3'd0;
      cmd_sr   <= 7'd0;
      nib_cnt  <= 3'd0;
      addr_sr  <= '0;
      ptr      <= '0;
      is_read  <= 1'b0;
      w_hi     <= 4'h0;
      w_phase  <= 1'b0;
      wait_cnt <= '0;
      rd_lo    <= 1'b0;
    end else if (ce_s) begin
      bit_cnt  <= 3'd0;
      nib_cnt  <= 3'd0;
      w_phase  <= 1'b0;
      wait_cnt <= '0;
      rd_lo    <= 1'b0;
    end else begin
      case (state)
        S_CMD: begin
          if (rise_c) begin
            cmd_sr <= cmd_byte_c[6:0];
            if (cmd_last_c) begin
              bit_cnt <= 3'd0;
              is_read <= (cmd_byte_c == OP_READ);
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        S_ADDR: begin
          if (rise_c) begin
            addr_sr <= addr_nx_c;
            if (addr_last_c) begin
              nib_cnt <= 3'd0;
              ptr     <= addr_nx_c;
            end else begin
              nib_cnt <= nib_cnt + 3'd1;
            end
          end
        end
        S_WDATA: begin
          if (rise_c) begin
            if (w_phase) ptr <= ptr + ADDR_WIDTH'(1);
            else         w_hi <= sio_s;
            w_phase <= ~w_phase;
          end
        end
        S_WAIT: begin
          if (fall_c) begin
            if (wait_last_c) begin
              wait_cnt <= '0;
              rd_lo    <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end
        end
        S_RDATA: begin
          if (fall_c) begin
            if (rd_lo) ptr <= ptr + ADDR_WIDTH'(1);
            rd_lo <= ~rd_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Byte RAM; the bus write is last so it wins an address collision with the backdoor
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (dbg_we)   mem[dbg_addr] <= dbg_wdata;
    if (bus_we_c) mem[ptr] <= {w_hi, sio_s};
    rd_byte <= mem[ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_rdata <= 8'h00;
    else     dbg_rdata <= mem[dbg_addr];
  end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder: drives SPI/QPI transactions into psram_qpi_responder.
// It checks RAM contents through the debug port, and checks read nibbles against a scoreboard queue.
module tb_psram_qpi_responder;
  localparam int unsigned AW = 10;
  localparam int WAIT_CYCLES = 6;
  localparam int H = 6;  // clk cycles per sclk half period

  logic          clk = 1'b0;
  logic          rst, sclk, ce;
  logic [3:0]    sio_in, sio_out;
  logic          sio_oe, qpi_mode, cmd_err;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_wdata, dbg_rdata;

  psram_qpi_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ce(ce), .sio_in(sio_in),
    .sio_out(sio_out), .sio_oe(sio_oe), .qpi_mode(qpi_mode), .cmd_err(cmd_err),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0]   addr;
    logic [7:0]    d0;
    logic [7:0]    d1;
    logic [AW-1:0] a0;  // RAM location expected to hold d0
    logic [AW-1:0] a1;  // RAM location expected to hold d1
  } wvec_t;

  int         checks = 0;
  int         failures = 0;
  logic       oe_seen;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic half();
    repeat (H) @(negedge clk);
  endtask

  // One sclk cycle: data set while low, sampled by the device on the rise, ends on a fall
  task automatic tick(input logic [3:0] d);
    sio_in = d;
    half();
    sclk = 1'b1;
    half();
    sclk = 1'b0;
  endtask

  task automatic start_txn();
    ce = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_txn();
    half();
    ce = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      tick({3'b000, b[i]});
      oe_seen = oe_seen | sio_oe;
    end
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    tick(b[7:4]);
    tick(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) tick(a[i*4 +: 4]);
  endtask

  task automatic spi_cmd(input logic [7:0] op);
    start_txn();
    spi_byte(op);
    end_txn();
  endtask

  task automatic qpi_cmd(input logic [7:0] op);
    start_txn();
    qpi_byte(op);
    end_txn();
  endtask

  task automatic qpi_write2(input logic [23:0] a, input logic [7:0] d0, input logic [7:0] d1);
    start_txn();
    qpi_byte(8'h38);
    send_addr(a);
    qpi_byte(d0);
    qpi_byte(d1);
    end_txn();
  endtask

  task automatic dbg_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    dbg_addr = a;
    repeat (2) @(negedge clk);
    check(name, 32'(dbg_rdata), 32'(exp));
  endtask

  task automatic dbg_write(input logic [AW-1:0] a, input logic [7:0] d);
    dbg_we = 1'b1;
    dbg_addr = a;
    dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic sb_push2(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0[7:4]);
    exp_q.push_back(b0[3:0]);
    exp_q.push_back(b1[7:4]);
    exp_q.push_back(b1[3:0]);
  endtask

  task automatic sb_pop_check(input string name);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      failures++;
      checks++;
      $display("FAIL %s: got %0h expected nothing (scoreboard empty)", name, sio_out);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(sio_out), 32'(e));
    end
  endtask

  // The 6th address fall is the first wait fall; data follows the WAIT_CYCLES-th fall
  task automatic qpi_read(input logic [23:0] a, input int nbytes, input string tag);
    start_txn();
    qpi_byte(8'hEB);
    send_addr(a);
    for (int i = 0; i < WAIT_CYCLES - 2; i++) begin
      tick(4'h0);
      half();
      check({tag, "_wait_oe"}, 32'(sio_oe), 32'd0);
    end
    for (int i = 0; i < 2 * nbytes; i++) begin
      tick(4'h0);
      half();
      check({tag, "_oe"}, 32'(sio_oe), 32'd1);
      sb_pop_check({tag, "_nib"});
    end
    end_txn();
    check({tag, "_oe_after_ce"}, 32'(sio_oe), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t vec[3];
    vec[0] = '{24'h000010, 8'hA5, 8'h3C, 10'h010, 10'h011};
    vec[1] = '{24'h1203FF, 8'h5A, 8'hC3, 10'h3FF, 10'h000};
    vec[2] = '{24'hABC155, 8'h96, 8'h0F, 10'h155, 10'h156};

    rst = 1'b1; sclk = 1'b0; ce = 1'b1; sio_in = 4'h0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = 8'h00;
    oe_seen = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_sio_out", 32'(sio_out), 32'd0);
    check("rst_sio_oe", 32'(sio_oe), 32'd0);
    check("rst_qpi", 32'(qpi_mode), 32'd0);
    check("rst_err", 32'(cmd_err), 32'd0);
    check("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // SPI init: reset-enable, reset, enter QPI
    spi_cmd(8'h66);
    spi_cmd(8'h99);
    spi_cmd(8'h35);
    check("init_qpi", 32'(qpi_mode), 32'd1);
    check("init_err", 32'(cmd_err), 32'd0);
    check("init_oe_never", 32'(oe_seen), 32'd0);

    for (int v = 0; v < 3; v++) begin
      qpi_write2(vec[v].addr, vec[v].d0, vec[v].d1);
      dbg_check($sformatf("wr%0d_b0", v), vec[v].a0, vec[v].d0);
      dbg_check($sformatf("wr%0d_b1", v), vec[v].a1, vec[v].d1);
    end

    for (int v = 0; v < 3; v++) begin
      sb_push2(vec[v].d0, vec[v].d1);
      qpi_read(vec[v].addr, 2, $sformatf("rd%0d", v));
    end

    // Read wrapping from the top of RAM to address 0
    dbg_write(10'h3FF, 8'h11);
    dbg_write(10'h000, 8'h22);
    sb_push2(8'h11, 8'h22);
    qpi_read(24'h0003FF, 2, "rd_wrap");

    // Abort after one write nibble leaves RAM untouched, then a clean byte write
    dbg_write(10'h020, 8'h77);
    start_txn();
    qpi_byte(8'h38);
    send_addr(24'h000020);
    tick(4'h1);
    end_txn();
    dbg_check("abort_ram", 10'h020, 8'h77);
    qpi_write2(24'h000020, 8'h4B, 8'hD2);
    dbg_check("post_abort_wr", 10'h020, 8'h4B);

    // Reset without reset-enable keeps QPI; with it, QPI exits
    qpi_cmd(8'h99);
    check("rst_unarmed_qpi", 32'(qpi_mode), 32'd1);
    qpi_cmd(8'h66);
    qpi_cmd(8'h99);
    check("rst_armed_qpi", 32'(qpi_mode), 32'd0);
    spi_cmd(8'h35);
    check("reenter_qpi", 32'(qpi_mode), 32'd1);
    qpi_cmd(8'hF5);
    check("f5_qpi", 32'(qpi_mode), 32'd0);
    check("f5_err", 32'(cmd_err), 32'd0);

    // Unknown QPI opcode followed by write-shaped traffic
    spi_cmd(8'h35);
    oe_seen = 1'b0;
    start_txn();
    qpi_byte(8'h9F);
    send_addr(24'h000020);
    qpi_byte(8'hEE);
    oe_seen = sio_oe;
    end_txn();
    check("err_flag", 32'(cmd_err), 32'd1);
    check("err_qpi_kept", 32'(qpi_mode), 32'd1);
    check("err_oe", 32'(oe_seen), 32'd0);
    dbg_check("err_ram_kept", 10'h020, 8'h4B);

    // Reset while read data is being driven
    exp_q.push_back(4'hA);
    start_txn();
    qpi_byte(8'hEB);
    send_addr(24'h000010);
    for (int i = 0; i < WAIT_CYCLES - 1; i++) tick(4'h0);
    half();
    check("mid_rd_oe", 32'(sio_oe), 32'd1);
    sb_pop_check("mid_rd_nib");
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_oe", 32'(sio_oe), 32'd0);
    check("mid_rst_qpi", 32'(qpi_mode), 32'd0);
    check("mid_rst_err", 32'(cmd_err), 32'd0);
    check("mid_rst_sio_out", 32'(sio_out), 32'd0);
    rst = 1'b0;
    ce = 1'b1;
    repeat (8) @(negedge clk);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
